// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcode encoding, FSM states
// and bit positions inside the {overflow, negative, zero} flag vector.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ADD   = 3'b000,
    SUB   = 3'b001,
    AND   = 3'b010,
    OR    = 3'b011,
    XOR   = 3'b100,
    INC   = 3'b101,
    PASSA = 3'b110,
    PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } seq_state_e;

  localparam int FLG_OVF  = 2;
  localparam int FLG_NEG  = 1;
  localparam int FLG_ZERO = 0;

endpackage

// File: rtl/alu_regbank.sv
// NREGS x BW register bank: one synchronous write port, two registered operand
// read ports and one combinational debug read port; asynchronous active-low clear.
module alu_regbank
  import alu_seq_pkg::*;
#(
  parameter int BW    = 16,
  parameter int NREGS = 8,
  parameter int RAW   = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we_i,
  input  logic [RAW-1:0] waddr_i,
  input  logic [BW-1:0]  wdata_i,
  input  logic           re_i,
  input  logic [RAW-1:0] raddr_a_i,
  input  logic [RAW-1:0] raddr_b_i,
  output logic [BW-1:0]  rdata_a_o,
  output logic [BW-1:0]  rdata_b_o,
  input  logic [RAW-1:0] dbg_addr_i,
  output logic [BW-1:0]  dbg_data_o
);

  logic [BW-1:0] regs_q [NREGS];
  logic [BW-1:0] rdata_a_q, rdata_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Operand registers hold their value outside the read cycle so the ALU inputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else if (re_i) begin
      rdata_a_q <= regs_q[raddr_a_i];
      rdata_b_q <= regs_q[raddr_b_i];
    end
  end

  assign rdata_a_o  = rdata_a_q;
  assign rdata_b_o  = rdata_b_q;
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state controller (IDLE/READ/EXEC/WRITE) driving an external ALU against a
// register bank. Define ALU_SEQ_SATURATE_EN to saturate overflowing add/sub results.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int BW    = 16,
  parameter int NREGS = 8,
  localparam int RAW  = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           rst_n,
  // instr_* is accepted on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE and nothing is buffered otherwise.
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [2:0]     instr_op,
  input  logic [RAW-1:0] instr_rd,
  input  logic [RAW-1:0] instr_ra,
  input  logic [RAW-1:0] instr_rb,
  output logic [BW-1:0]  alu_a,
  output logic [BW-1:0]  alu_b,
  output logic [2:0]     alu_op,
  input  logic [BW:0]    alu_out,
  input  logic [2:0]     alu_flags,
  output logic           done,
  output logic [2:0]     flags,
  input  logic [RAW-1:0] dbg_addr,
  output logic [BW-1:0]  dbg_data
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_READ  = ST_READ;
  localparam logic [1:0] S_EXEC  = ST_EXEC;
  localparam logic [1:0] S_WRITE = ST_WRITE;

  logic [1:0]     state_q, state_d;
  alu_op_e        op_q;
  logic [RAW-1:0] rd_q, ra_q, rb_q;
  logic [BW-1:0]  res_q, res_d;
  logic [2:0]     flags_q, flags_d;
  logic [BW-1:0]  opa_q, opb_q;
  logic           unused_carry;

  assign unused_carry = alu_out[BW];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_d   = alu_out[BW-1:0];
    flags_d = alu_flags;
`ifdef ALU_SEQ_SATURATE_EN
    if ((op_q == ADD || op_q == SUB) && alu_flags[FLG_OVF]) begin
      res_d = opa_q[BW-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
      flags_d[FLG_OVF]  = 1'b1;
      flags_d[FLG_NEG]  = res_d[BW-1];
      flags_d[FLG_ZERO] = ~|res_d;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= ADD;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && instr_valid) begin
        op_q <= alu_op_e'(instr_op);
        rd_q <= instr_rd;
        ra_q <= instr_ra;
        rb_q <= instr_rb;
      end
      if (state_q == S_EXEC) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  alu_regbank #(.BW(BW), .NREGS(NREGS), .RAW(RAW)) u_regbank (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (state_q == S_WRITE),
    .waddr_i    (rd_q),
    .wdata_i    (res_q),
    .re_i       (state_q == S_READ),
    .raddr_a_i  (ra_q),
    .raddr_b_i  (rb_q),
    .rdata_a_o  (opa_q),
    .rdata_b_o  (opb_q),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // ALU inputs are forced to zero outside EXEC so the datapath is quiet between instructions.
  assign alu_a       = (state_q == S_EXEC) ? opa_q : '0;
  assign alu_b       = (state_q == S_EXEC) ? opb_q : '0;
  assign alu_op      = (state_q == S_EXEC) ? op_q  : 3'b000;
  assign instr_ready = (state_q == S_IDLE);
  assign done        = (state_q == S_WRITE);
  assign flags       = flags_q;

endmodule
